// File: rtl/alu_iter_if.sv
// Request/response bundle between the operand read stage, alu_iter and writeback.
interface alu_iter_if #(parameter int W = 8);
    logic         start_i;
    logic [4:0]   alu_cmd;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         sc_i;
    logic         busy_o;
    logic         valid_o;
    logic [W-1:0] rslt;
    logic [W-1:0] hi_o;
    logic         sc_o;
    logic         cnd;
    logic         zero;
    logic         pari;

    modport master (output start_i, alu_cmd, inA, inB, sc_i,
                    input  busy_o, valid_o, rslt, hi_o, sc_o, cnd, zero, pari);
    modport slave  (input  start_i, alu_cmd, inA, inB, sc_i,
                    output busy_o, valid_o, rslt, hi_o, sc_o, cnd, zero, pari);
endinterface

// File: rtl/alu_iter.sv
// Registered ALU: single-cycle ops plus iterative shift-add MUL and restoring DIVU.
// Optional macro ALU_SAT_EN adds unsigned saturating ADDS (11) / SUBS (12).
module alu_iter #(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_iter_if.slave bus
);
    localparam int CNT_W = $clog2(W) + 1;

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_XOR = 5'd3,
                           OP_CMP = 5'd4, OP_CEQ = 5'd5, OP_LSL = 5'd6, OP_LSR = 5'd7,
                           OP_MOV = 5'd8, OP_MUL = 5'd9, OP_DIV = 5'd10;
`ifdef ALU_SAT_EN
    localparam logic [4:0] OP_ADDS = 5'd11, OP_SUBS = 5'd12;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state, state_nxt;

    // op_r holds the multiplicand (MUL) or divisor (DIV); q_r the multiplier or dividend/quotient
    logic [W-1:0]     op_r, q_r, acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     rslt_r, hi_r;
    logic             sc_r, cnd_r, zero_r, pari_r, valid_r;

    logic [W-1:0] a, b;
    logic         last, ld;
    logic         wr, sc_nxt, cnd_nxt;
    logic [W-1:0] res_nxt, hi_nxt;

    assign a    = bus.inA;
    assign b    = bus.inB;
    assign last = (cnt_r == CNT_W'(W - 1));

    logic [W:0] add_full, sub_full;
    assign add_full = {1'b0, a} + {1'b0, b} + (W+1)'(bus.sc_i);
    assign sub_full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1) - (W+1)'(bus.sc_i);
`ifdef ALU_SAT_EN
    logic [W:0] adds_full;
    assign adds_full = {1'b0, a} + {1'b0, b};
`endif

    logic [W:0]   mul_sum;
    logic [W-1:0] mul_acc_nxt, mul_q_nxt;
    assign mul_sum     = {1'b0, acc_r} + (q_r[0] ? {1'b0, op_r} : '0);
    assign mul_acc_nxt = mul_sum[W:1];
    assign mul_q_nxt   = {mul_sum[0], q_r[W-1:1]};

    logic [W:0]   div_sh, div_diff;
    logic         div_ok;
    logic [W-1:0] div_acc_nxt, div_q_nxt;
    assign div_sh      = {acc_r, q_r[W-1]};
    assign div_diff    = div_sh - {1'b0, op_r};
    assign div_ok      = (div_sh >= {1'b0, op_r});
    assign div_acc_nxt = div_ok ? div_diff[W-1:0] : div_sh[W-1:0];
    assign div_q_nxt   = {q_r[W-2:0], div_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start_i) begin
                if (bus.alu_cmd == OP_MUL)                    state_nxt = MUL;
                else if (bus.alu_cmd == OP_DIV && b != '0)    state_nxt = DIV;
            end
            MUL, DIV: if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld      = 1'b0;
        wr      = 1'b0;
        res_nxt = '0;
        hi_nxt  = '0;
        sc_nxt  = 1'b0;
        cnd_nxt = 1'b0;
        case (state)
            IDLE: if (bus.start_i) begin
                if (bus.alu_cmd == OP_MUL || (bus.alu_cmd == OP_DIV && b != '0)) begin
                    ld = 1'b1;
                end else begin
                    wr = 1'b1;
                    case (bus.alu_cmd)
                        OP_ADD: {sc_nxt, res_nxt} = add_full;
                        OP_SUB: {sc_nxt, res_nxt} = sub_full;
                        OP_AND: res_nxt = a & b;
                        OP_XOR: res_nxt = a ^ b;
                        OP_CMP: cnd_nxt = (a > b);
                        OP_CEQ: cnd_nxt = (a == b);
                        OP_LSL: {sc_nxt, res_nxt} = {a, bus.sc_i};
                        OP_LSR: {res_nxt, sc_nxt} = {bus.sc_i, a};
                        OP_MOV: res_nxt = b;
                        OP_DIV: begin  // divide by zero, resolved without iterating
                            res_nxt = '1;
                            hi_nxt  = a;
                            sc_nxt  = 1'b1;
                        end
`ifdef ALU_SAT_EN
                        OP_ADDS: begin
                            sc_nxt  = adds_full[W];
                            res_nxt = adds_full[W] ? '1 : adds_full[W-1:0];
                        end
                        OP_SUBS: begin
                            // carry-out of A+~B+1 is 1 whenever there is no borrow, as for SUB
                            sc_nxt  = 1'b1;
                            res_nxt = (a < b) ? '0 : a - b;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            MUL: if (last) begin
                wr      = 1'b1;
                res_nxt = mul_q_nxt;
                hi_nxt  = mul_acc_nxt;
                sc_nxt  = |mul_acc_nxt;
            end
            DIV: if (last) begin
                wr      = 1'b1;
                res_nxt = div_q_nxt;
                hi_nxt  = div_acc_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= '0; q_r <= '0; acc_r <= '0; cnt_r <= '0;
            rslt_r <= '0; hi_r <= '0; sc_r <= 1'b0; cnd_r <= 1'b0;
            zero_r <= 1'b1; pari_r <= 1'b0; valid_r <= 1'b0;
        end else begin
            if (ld) begin
                op_r  <= (bus.alu_cmd == OP_MUL) ? a : b;
                q_r   <= (bus.alu_cmd == OP_MUL) ? b : a;
                acc_r <= '0;
                cnt_r <= '0;
            end else if (state == MUL) begin
                acc_r <= mul_acc_nxt;
                q_r   <= mul_q_nxt;
                cnt_r <= cnt_r + 1'b1;
            end else if (state == DIV) begin
                acc_r <= div_acc_nxt;
                q_r   <= div_q_nxt;
                cnt_r <= cnt_r + 1'b1;
            end
            valid_r <= wr;
            if (wr) begin
                rslt_r <= res_nxt;
                hi_r   <= hi_nxt;
                sc_r   <= sc_nxt;
                cnd_r  <= cnd_nxt;
                zero_r <= (res_nxt == '0);
                pari_r <= ^res_nxt;
            end
        end
    end

    assign bus.busy_o  = (state != IDLE);
    assign bus.valid_o = valid_r;
    assign bus.rslt    = rslt_r;
    assign bus.hi_o    = hi_r;
    assign bus.sc_o    = sc_r;
    assign bus.cnd     = cnd_r;
    assign bus.zero    = zero_r;
    assign bus.pari    = pari_r;
endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter at W=8 with hand-computed expectations.
module tb_alu_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_iter_if #(.W(8)) bus ();
    alu_iter #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] c, input logic [7:0] a, input logic [7:0] b, input logic s);
        bus.start_i = 1'b1;
        bus.alu_cmd = c;
        bus.inA     = a;
        bus.inB     = b;
        bus.sc_i    = s;
    endtask

    task automatic run1(input logic [4:0] c, input logic [7:0] a, input logic [7:0] b, input logic s);
        drive(c, a, b, s);
        tick();
        bus.start_i = 1'b0;
    endtask

    // Launch then count cycles busy_o stays high, bounded.
    task automatic run_iter(input logic [4:0] c, input logic [7:0] a, input logic [7:0] b, output int n);
        run1(c, a, b, 1'b0);
        n = 0;
        while (bus.busy_o && n < 40) begin
            n++;
            tick();
        end
    endtask

    int  n;
    logic seen_valid;

    initial begin
        bus.start_i = 1'b0; bus.alu_cmd = '0; bus.inA = '0; bus.inB = '0; bus.sc_i = 1'b0;
        tick(); tick();
        chk("rst_rslt", bus.rslt, 0);
        chk("rst_hi", bus.hi_o, 0);
        chk("rst_zero", bus.zero, 1);
        chk("rst_flags", {bus.sc_o, bus.cnd, bus.pari, bus.valid_o, bus.busy_o}, 0);
        rst_n = 1'b1;
        tick();

        // ADD then back-to-back SUB
        drive(5'd0, 8'hF0, 8'h20, 1'b1);
        tick();
        chk("add_rslt", bus.rslt, 16'h11);
        chk("add_sc", bus.sc_o, 1);
        chk("add_zp", {bus.zero, bus.pari}, 0);
        chk("add_valid", bus.valid_o, 1);
        drive(5'd1, 8'h05, 8'h05, 1'b0);
        tick();
        bus.start_i = 1'b0;
        chk("sub_rslt", bus.rslt, 0);
        chk("sub_sc", bus.sc_o, 1);
        chk("sub_zero", bus.zero, 1);
        chk("sub_valid", bus.valid_o, 1);
        tick();
        chk("valid_pulse", bus.valid_o, 0);
        chk("hold_rslt", bus.rslt, 0);

        // MUL
        run_iter(5'd9, 8'd13, 8'd11, n);
        chk("mul_busy_cyc", n, 8);
        chk("mul_valid", {bus.valid_o, bus.busy_o}, 2'b10);
        chk("mul_rslt", bus.rslt, 16'h8F);
        chk("mul_hi", bus.hi_o, 0);
        chk("mul_sc_par", {bus.sc_o, bus.pari}, 2'b01);
        run_iter(5'd9, 8'h10, 8'h20, n);
        chk("mul2_rslt", {bus.hi_o, bus.rslt}, 16'h0200);
        chk("mul2_sc_zero", {bus.sc_o, bus.zero}, 2'b11);

        // DIVU
        run_iter(5'd10, 8'd200, 8'd7, n);
        chk("div_busy_cyc", n, 8);
        chk("div_valid", bus.valid_o, 1);
        chk("div_res", {bus.hi_o, bus.rslt}, 16'h041C);
        chk("div_sc", bus.sc_o, 0);
        run1(5'd10, 8'h55, 8'h00, 1'b0);
        chk("div0_valid_busy", {bus.valid_o, bus.busy_o}, 2'b10);
        chk("div0_res", {bus.hi_o, bus.rslt}, 16'h55FF);
        chk("div0_sc", bus.sc_o, 1);

        // MUL with ignored starts and operand toggling
        run1(5'd9, 8'd3, 8'd5, 1'b0);
        n = 0;
        while (bus.busy_o && n < 40) begin
            if (n >= 1 && n <= 3) drive(5'd0, 8'(n * 37), 8'h77, 1'b1);
            else bus.start_i = 1'b0;
            n++;
            tick();
        end
        bus.start_i = 1'b0;
        chk("ign_busy_cyc", n, 8);
        chk("ign_rslt", bus.rslt, 16'h0F);
        chk("ign_valid", bus.valid_o, 1);

        // Reset mid-MUL
        run1(5'd9, 8'd3, 8'd5, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("abort_rslt", {bus.hi_o, bus.rslt}, 0);
        chk("abort_flags", {bus.zero, bus.sc_o, bus.pari, bus.valid_o, bus.busy_o}, 5'b10000);
        tick();
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen_valid |= bus.valid_o;
        end
        chk("abort_no_valid", seen_valid, 0);

        // Compares and cnd clearing
        run1(5'd4, 8'h80, 8'h7F, 1'b0);
        chk("cmp_cnd", bus.cnd, 1);
        chk("cmp_rz", {bus.rslt, bus.zero}, 9'h001);
        run1(5'd5, 8'h3C, 8'h3C, 1'b0);
        chk("ceq_cnd", bus.cnd, 1);
        run1(5'd0, 8'h01, 8'h02, 1'b0);
        chk("add_cnd_clr", {bus.cnd, bus.rslt}, 9'h003);
        run1(5'd15, 8'h01, 8'h02, 1'b1);
        chk("inv_rz", {bus.hi_o, bus.rslt, bus.zero}, 17'h00001);

        // Remaining single-cycle ops
        run1(5'd6, 8'h81, 8'h00, 1'b1);
        chk("lsl", {bus.sc_o, bus.rslt}, 9'h103);
        run1(5'd7, 8'h81, 8'h00, 1'b1);
        chk("lsr", {bus.sc_o, bus.rslt}, 9'h1C0);
        run1(5'd2, 8'hF0, 8'h3C, 1'b1);
        chk("and", {bus.sc_o, bus.rslt}, 9'h030);
        run1(5'd3, 8'hF0, 8'h3C, 1'b0);
        chk("xor", bus.rslt, 16'hCC);
        run1(5'd8, 8'h00, 8'h5A, 1'b0);
        chk("mov", {bus.rslt, bus.pari}, 9'hB4);

`ifdef ALU_SAT_EN
        run1(5'd11, 8'hF0, 8'h20, 1'b0);
        chk("adds_sat", {bus.sc_o, bus.rslt}, 9'h1FF);
        run1(5'd12, 8'h10, 8'h20, 1'b0);
        chk("subs_sat", {bus.sc_o, bus.rslt, bus.zero}, 10'h201);
`else
        run1(5'd0, 8'hF0, 8'h20, 1'b1);
        run1(5'd11, 8'hF0, 8'h20, 1'b0);
        chk("cmd11_inv", {bus.sc_o, bus.rslt, bus.zero}, 10'h001);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, registered successor to the datapath ALU. It accepts one operation per start strobe and holds results and flags in registers until the next completion.
- Keeps the existing single-cycle op set: ADD/SUB/AND/XOR/CMP/CEQ/LSL/LSR/MOV.
- Adds multi-cycle unsigned multiply and divide using a shift-add and restoring-division engine.
- Sits between the register file read stage and writeback. The controller stalls on busy_o.

Parameters:
- W, 8, datapath width in bits; legal values are W >= 4.
- CNT_W, $clog2(W)+1, width of the iteration counter; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  launches the op on alu_cmd/inA/inB/sc_i; sampled only in IDLE.
- alu_cmd  in  5  operation code.
- inA  in  W  operand A.
- inB  in  W  operand B.
- sc_i  in  1  carry/borrow/shift-in.
- busy_o  out  1  high while a MUL/DIV is iterating.
- valid_o  out  1  one-cycle pulse when rslt/flags update.
- rslt  out  W  registered result.
- hi_o  out  W  MUL high half or DIV remainder; 0 for all other ops.
- sc_o  out  1  registered carry/shift-out/overflow.
- cnd  out  1  registered compare result.
- zero  out  1  registered (rslt == 0).
- pari  out  1  registered ^rslt.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rslt, hi_o, counter = 0; sc_o, cnd, valid_o, busy_o = 0; zero=1; pari=0.
- Flags zero and pari are always computed from the value being written into rslt, in the same cycle it is written.
- Opcodes:
  - 0 ADD: {sc_o,rslt} = A+B+sc_i.
  - 1 SUB: {sc_o,rslt} = A+~B+1-sc_i, full W+1-bit result.
  - 2 AND.
  - 3 XOR.
  - 4 CMP: cnd = A>B unsigned, rslt=0.
  - 5 CEQ: cnd = A==B, rslt=0.
  - 6 LSL: {sc_o,rslt} = {A,sc_i}.
  - 7 LSR: {rslt,sc_o} = {sc_i,A}.
  - 8 MOV: rslt=B.
  - 9 MUL: {hi_o,rslt} = A*B unsigned; sc_o = |hi_o.
  - 10 DIVU: rslt = A/B, hi_o = A%B, sc_o=0.
  - Any other code: rslt=0, hi_o=0, sc_o=0, cnd=0, so zero=1.
- cnd is cleared for every op except CMP/CEQ. sc_o is cleared for ops that do not define it.
- Single-cycle ops (0-8, invalid): start_i in IDLE → outputs registered at that edge; valid_o high the following cycle. Latency 1; back-to-back starts every cycle are allowed.
- FSM states:
  - IDLE: start with cmd 9 → MUL; cmd 10 → DIV; otherwise stay in IDLE. On a MUL/DIV start, latch A, B, cmd; clear the accumulator; counter=0; busy_o=1 from the next cycle.
  - MUL: one shift-add per cycle, LSB of multiplier first. After W iterations, write rslt/hi_o/flags, pulse valid_o, go to IDLE. Latency W+1 cycles from start to valid_o.
  - DIV: one restoring step per cycle, MSB first. After W iterations, write outputs → IDLE. Latency W+1.
- Divide by zero: no iteration; result at latency 1 with rslt = all ones, hi_o = A, sc_o=1, valid_o pulses.
- start_i while busy_o=1: ignored, with no queuing and no effect on the running op. busy_o falls in the same cycle valid_o rises, so a new start is accepted that cycle.
- Operand changes during MUL/DIV: no effect, because operands are latched at start.
- rst_n asserted mid-operation: immediate abort to reset values; no valid_o pulse.
- Outputs hold their last values between valid_o pulses.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: cmds 11 ADDS and 12 SUBS are unsigned saturating. On overflow or underflow, rslt clamps to all ones or 0 respectively, with sc_o=1; otherwise they behave as ADD/SUB with sc_i ignored.
- Undefined: 11 and 12 decode as invalid ops (rslt=0, zero=1, sc_o=0). No saturation logic is generated.

Test Plan:
- ADD, W=8, A=0xF0, B=0x20, sc_i=1 → next cycle rslt=0x11, sc_o=1, zero=0, pari=0, valid_o one pulse; followed back-to-back by SUB A=0x05, B=0x05, sc_i=0 → rslt=0x00, sc_o=1, zero=1.
- MUL A=13, B=11 → busy_o high 8 cycles, valid_o at cycle 9, rslt=0x8F, hi_o=0x00, sc_o=0, pari=1. Then A=0x10, B=0x20 → rslt=0x00, hi_o=0x02, sc_o=1, zero=1.
- DIVU A=200, B=7 → rslt=0x1C, hi_o=0x04 at latency 9. DIVU A=0x55, B=0 → latency 1, rslt=0xFF, hi_o=0x55, sc_o=1.
- Start MUL A=3, B=5; pulse start_i with ADD on cycles 2-4 and toggle inA → ignored, final rslt=0x0F. Repeat with rst_n low at cycle 4 → all outputs at reset values, no valid_o.
- CMP A=0x80, B=0x7F → cnd=1, rslt=0, zero=1. CEQ A=B=0x3C → cnd=1. Next op ADD → cnd=0. cmd=15 → rslt=0, zero=1.
- ALU_SAT_EN defined: ADDS 0xF0+0x20 → rslt=0xFF, sc_o=1; SUBS 0x10-0x20 → rslt=0x00, sc_o=1. Undefined: cmd 11 → rslt=0, zero=1, sc_o=0.
